// File: rtl/mdu_pkg.sv
// mdu_defs: shared definitions for the multiply/divide unit.
//   mdu_op_e    - operation codes carried on the 3-bit op port
//   mdu_state_e - control FSM state encoding
//   MDU_*_CYCLES_DEF - default multi-cycle latencies
package mdu_defs;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational datapath of the multiply/divide unit.
//   op  [2:0]  - operation code (mdu_op_e)
//   A   [31:0] - rs operand (multiplicand / dividend)
//   B   [31:0] - rt operand (multiplier / divisor)
//   res [63:0] - {hi, lo} result
//   ok         - 0 when the result must not replace HI/LO (divide by zero)
import mdu_defs::*;

module mdu_arith (
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [63:0] res,
    output logic        ok
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] b_safe;
    logic [31:0] q_s, r_s, q_u, r_u;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'b0, A} * {32'b0, B};

    assign div_zero = (B == 32'h0);
    assign div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

    // Keep the divider away from the zero and overflow cases; those results
    // are selected explicitly below.
    assign b_safe = (div_zero || div_ovf) ? 32'd1 : B;

    assign q_s = $signed(A) / $signed(b_safe);
    assign r_s = $signed(A) % $signed(b_safe);
    assign q_u = A / b_safe;
    assign r_u = A % b_safe;

    always_comb begin
        res = 64'h0;
        ok  = 1'b1;
        case (op)
            MDU_MULT:  res = prod_s;
            MDU_MULTU: res = prod_u;
            MDU_DIV: begin
                if (div_zero)     ok  = 1'b0;
                else if (div_ovf) res = {32'h0, 32'h8000_0000};
                else              res = {r_s, q_s};
            end
            MDU_DIVU: begin
                if (div_zero) ok  = 1'b0;
                else          res = {r_u, q_u};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// mdu: multiply/divide unit owning the architectural HI/LO registers.
//   clk         - clock, rising edge
//   reset       - asynchronous active-low reset
//   start       - one-cycle request qualifying op
//   op    [2:0] - MULT/MULTU/DIV/DIVU/MTHI/MTLO
//   A, B [31:0] - rs / rt operands
//   rd_hi       - read select for out (1 = HI, 0 = LO)
//   busy        - multi-cycle operation in flight
//   out  [31:0] - combinational HI/LO read value
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | accepts start; MTHI/MTLO write immediately
// ST_BUSY | counting down; result committed to HI/LO when cnt goes 1->0
import mdu_defs::*;

module mdu #(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_hi,
    output logic        busy,
    output logic [31:0] out
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    mdu_state_e  state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [31:0] hi, hi_next, lo, lo_next;
    logic [31:0] hi_tmp, hi_tmp_next, lo_tmp, lo_tmp_next;
    logic [63:0] arith_res;
    logic        arith_ok;

    mdu_arith u_arith (
        .op  (op),
        .A   (A),
        .B   (B),
        .res (arith_res),
        .ok  (arith_ok)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            hi_tmp <= '0;
            lo_tmp <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            hi     <= hi_next;
            lo     <= lo_next;
            hi_tmp <= hi_tmp_next;
            lo_tmp <= lo_tmp_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        hi_next     = hi;
        lo_next     = lo;
        hi_tmp_next = hi_tmp;
        lo_tmp_next = lo_tmp;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                            // A divide by zero still runs the full busy period;
                            // it stages the current HI/LO so the commit is a no-op.
                            if (arith_ok) {hi_tmp_next, lo_tmp_next} = arith_res;
                            else          {hi_tmp_next, lo_tmp_next} = {hi, lo};
                            cnt_next   = (op == MDU_MULT || op == MDU_MULTU)
                                         ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                            state_next = ST_BUSY;
                        end
                        MDU_MTHI: hi_next = A;
                        MDU_MTLO: lo_next = A;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                cnt_next = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    hi_next    = hi_tmp;
                    lo_next    = lo_tmp;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_BUSY);
    assign out  = rd_hi ? hi : lo;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;
    import mdu_defs::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        rd_hi = 1'b0;
    logic        busy;
    logic [31:0] out;

    int n_vec  = 0;
    int n_miss = 0;
    logic [31:0] cur_hi = 32'h0;
    logic [31:0] cur_lo = 32'h0;

    mdu dut (
        .clk   (clk),
        .reset (rst),
        .start (start),
        .op    (op),
        .A     (a),
        .B     (b),
        .rd_hi (rd_hi),
        .busy  (busy),
        .out   (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs[16];
    int   n_tab;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        rd_hi = 1'b1; #1; h = out;
        rd_hi = 1'b0; #1; l = out;
    endtask

    // Issues one request at the next falling edge and follows it to completion.
    // While busy, HI/LO must still show the values from before the request.
    task automatic apply(input vec_t v, input string name);
        logic [31:0] h, l;
        int lat;
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; b = v.b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (busy === 1'b1 && lat < 50) begin
            lat++;
            read_hilo(h, l);
            if (lat == 1) begin
                chk({name, " hi during busy"}, h, cur_hi);
                chk({name, " lo during busy"}, l, cur_lo);
            end
            @(posedge clk); #1;
        end
        chk({name, " latency"}, 32'(lat), 32'(v.lat));
        read_hilo(h, l);
        chk({name, " hi"}, h, v.hi);
        chk({name, " lo"}, l, v.lo);
        cur_hi = v.hi;
        cur_lo = v.lo;
    endtask

    initial begin
        logic [31:0] h, l;
        int lat;
        vec_t v;

        n_tab = 0;
        vecs[n_tab++] = '{MDU_MULT,  32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 5};
        vecs[n_tab++] = '{MDU_MULTU, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFD, 5};
        vecs[n_tab++] = '{MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[n_tab++] = '{MDU_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 10};
        vecs[n_tab++] = '{MDU_MTHI,  32'h1234_5678, 32'h0,         32'h1234_5678, 32'h7FFF_FFFC, 0};
        vecs[n_tab++] = '{MDU_MTLO,  32'h9ABC_DEF0, 32'h0,         32'h1234_5678, 32'h9ABC_DEF0, 0};
        vecs[n_tab++] = '{MDU_MULT,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5};
        vecs[n_tab++] = '{MDU_MULT,  32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0006, 5};
        vecs[n_tab++] = '{MDU_MULTU, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0006, 5};
        vecs[n_tab++] = '{MDU_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[n_tab++] = '{MDU_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 10};
        vecs[n_tab++] = '{MDU_MTHI,  32'h0000_0011, 32'h0,         32'h0000_0011, 32'h0000_0003, 0};
        vecs[n_tab++] = '{MDU_MTLO,  32'h0000_0022, 32'h0,         32'h0000_0011, 32'h0000_0022, 0};
        vecs[n_tab++] = '{MDU_DIV,   32'h0000_0005, 32'h0,         32'h0000_0011, 32'h0000_0022, 10};
        vecs[n_tab++] = '{MDU_DIVU,  32'h0000_0005, 32'h0,         32'h0000_0011, 32'h0000_0022, 10};
        vecs[n_tab++] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {31'b0, busy}, 32'h0);
        read_hilo(h, l);
        chk("reset hi", h, 32'h0);
        chk("reset lo", l, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < n_tab; i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // Request while busy: MTLO on busy cycle 2 must be dropped.
        @(negedge clk);
        start = 1'b1; op = MDU_MULT; a = 32'h0000_0003; b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        @(negedge clk);
        start = 1'b1; op = MDU_MTLO; a = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 2;
        read_hilo(h, l);
        chk("ignored mtlo lo", l, cur_lo);
        chk("ignored mtlo hi", h, cur_hi);
        while (busy === 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            if (busy === 1'b1) lat++;
        end
        chk("busy-ignore latency", 32'(lat), 32'd5);
        read_hilo(h, l);
        chk("busy-ignore hi", h, 32'hFFFF_FFFF);
        chk("busy-ignore lo", l, 32'hFFFF_FFFD);
        chk("busy-ignore idle", {31'b0, busy}, 32'h0);

        // Reset in the middle of a divide aborts it with no commit.
        @(negedge clk);
        start = 1'b1; op = MDU_DIV; a = 32'h0000_0064; b = 32'h0000_0007;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("pre-reset busy", {31'b0, busy}, 32'h1);
        rst = 1'b0;
        #1;
        chk("abort busy", {31'b0, busy}, 32'h0);
        read_hilo(h, l);
        chk("abort hi", h, 32'h0);
        chk("abort lo", l, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("post-abort busy", {31'b0, busy}, 32'h0);
        read_hilo(h, l);
        chk("post-abort hi", h, 32'h0);
        chk("post-abort lo", l, 32'h0);
        cur_hi = 32'h0;
        cur_lo = 32'h0;
        v = '{MDU_MULT, 32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 32'h0000_0023, 5};
        apply(v, "post-reset mult");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the pipelined MIPS core; sits in EX directly downstream of the GRF read ports and consumes the `rs`/`rt` operand values (after forwarding). It executes MULT/MULTU/DIV/DIVU with a fixed multi-cycle latency and owns the architectural HI/LO registers. It also services MTHI/MTLO writes and MFHI/MFLO reads, and exposes `busy` so the hazard unit can stall later MDU instructions.

## Interface
- `MULT_CYCLES`, default 5: cycles from accepted multiply to HI/LO update.
- `DIV_CYCLES`, default 10: cycles from accepted divide to HI/LO update.
- `clk` input 1: sole clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low. Low clears all state immediately.
- `start` input 1: one-cycle request; qualifies `op`.
- `op` input 3: operation code from the shared package (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
- `A` input 32: `rs` operand.
- `B` input 32: `rt` operand.
- `rd_hi` input 1: read select; 1 selects HI, 0 selects LO.
- `busy` output 1: multi-cycle operation in flight.
- `out` output 32: combinational read value, `rd_hi ? HI : LO` (MFHI/MFLO path).

## Operation
- States: IDLE, BUSY. Down-counter `cnt`, width `$clog2(DIV_CYCLES+1)`.
- IDLE, `start`=1, op in {MULT, MULTU}: latch result into `hi_tmp`/`lo_tmp`, load `cnt`=MULT_CYCLES, go to BUSY.
- IDLE, `start`=1, op in {DIV, DIVU}: same, with `cnt`=DIV_CYCLES.
- BUSY: decrement each cycle. On the edge where `cnt` goes 1→0, write HI←`hi_tmp`, LO←`lo_tmp` and return to IDLE.
- MTHI/MTLO with `start`=1 in IDLE: write HI or LO from `A` at that edge, with no busy period.
- Any `start` while BUSY is ignored, including MTHI/MTLO. The hazard unit guarantees it never issues one; the bench checks that it is ignored.
- MULT: signed 32×32→64, HI=[63:32], LO=[31:0]. MULTU: same, unsigned.
- DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. DIVU: unsigned.
- Division by zero (`B`=0): takes the full DIV_CYCLES busy period; HI and LO are left unchanged.
- Signed DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- HI/LO hold their old values during BUSY. `out` reflects the old values until commit.

## Timing
- Reset (`reset`=0): state IDLE, `cnt`=0, HI=LO=0, tmp regs=0, `busy`=0. `out`=0.
- Reset asserted during BUSY aborts the operation with no commit; the unit comes out of reset in IDLE.
- `busy` is registered. With `start` sampled at edge t0, `busy`=1 from t0 through t0+L, where L is the latency; it is high for exactly L cycles. HI/LO update at edge t0+L, and `busy`=0 after it.
- A new `start` is accepted at edge t0+L+1 at the earliest.
- MTHI/MTLO: the written value is visible on `out` immediately after the sampling edge.
- `out` has zero latency from `rd_hi`, HI and LO.

## Structure
- Shared package `mdu_defs`: op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO), state encoding, default latencies.
- One sub-module, `mdu_arith`: combinational block taking `op`, `A`, `B` and producing the 64-bit {hi,lo} result, including the divide-by-zero and overflow cases. The top level holds the FSM, counter and registers.

## Test plan
- MULT A=0x00000003, B=0xFFFFFFFF → `busy` high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFD. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFD.
- DIV A=0xFFFFFFF9 (−7), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with the same operands → LO=0x7FFFFFFC, HI=0x00000001.
- MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 in consecutive cycles → `out`=0x12345678 with `rd_hi`=1 and 0x9ABCDEF0 with `rd_hi`=0; `busy` stays 0.
- MULT started, then `start` with MTLO 0xDEADBEEF on busy cycle 2 → the MTLO is ignored, and LO equals the MULT result at commit. During busy, `out` shows the pre-MULT value.
- DIV with B=0 after HI=0x11, LO=0x22 → `busy` for 10 cycles, then HI=0x11, LO=0x22 unchanged. Signed DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIV started, `reset` pulled low on busy cycle 4 → `busy`=0 and HI=LO=0 immediately. After release, no commit occurs and a new MULT starts normally.
